id_ex_pipe: RTL and testbench

- Pipeline register between the decode stage and the execute stage.
- Captures every decode output each cycle and presents it to execute.
- Applies, in priority order: flush (jump), freeze (controller stall), and load-use bubble insertion.
- Derives the registered is_load flag consumed by decode's hazard check, and keeps saturating performance counters for stall, bubble and flush cycles.

---
 rtl/id_ex_pipe_pkg.sv | 51 +++++
 rtl/id_ex_pipe_sat_cnt.sv | 20 ++
 rtl/id_ex_pipe.sv | 126 ++++++++++++
 tb/tb_id_ex_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared decode/execute definitions: bus widths, opcodes, write-enable levels
// and the payload struct carried by the ID/EX register.
package id_ex_pipe_pkg;

    localparam int InstBus    = 32;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int MemAddrBus = 32;

    localparam logic [6:0]            INST_TYPE_L  = 7'b0000011;
    localparam logic [6:0]            INST_NOP_OP  = 7'b0000001;
    localparam logic [InstBus-1:0]    INST_NOP     = 32'h0000_0001;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] ZeroReg      = '0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;

    typedef struct packed {
        logic [InstBus-1:0]    inst;
        logic [MemAddrBus-1:0] inst_addr;
        logic [RegBus-1:0]     op1;
        logic [RegBus-1:0]     op2;
        logic [RegBus-1:0]     op1_jump;
        logic [RegBus-1:0]     op2_jump;
        logic [RegBus-1:0]     reg1_rdata;
        logic [RegBus-1:0]     reg2_rdata;
        logic                  reg_we;
        logic [RegAddrBus-1:0] reg_waddr;
        logic                  csr_we;
        logic [RegBus-1:0]     csr_rdata;
        logic [MemAddrBus-1:0] csr_waddr;
        logic                  valid;
        logic                  is_load;
    } id_ex_t;

    // Bubble/flush payload: a harmless instruction that never writes state.
    function automatic id_ex_t nop_state(input logic [InstBus-1:0] nop_inst);
        id_ex_t s;
        s           = '0;
        s.inst      = nop_inst;
        s.reg_we    = WriteDisable;
        s.csr_we    = WriteDisable;
        s.reg_waddr = ZeroReg;
        return s;
    endfunction

    function automatic logic is_load_inst(input logic [InstBus-1:0] inst, input logic we);
        return (inst[6:0] == INST_TYPE_L) && (we == WriteEnable);
    endfunction

endpackage

// File: rtl/id_ex_pipe_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset; clear beats increment.
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with flush > stall > bubble priority,
// registered load flag for the hazard check, and stall/bubble/flush counters.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int           CNT_W    = 32,
    parameter logic [31:0]  NOP_INST = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  bubble_i,
    input  logic                  cnt_clr_i,
    input  logic [InstBus-1:0]    inst_i,
    input  logic [MemAddrBus-1:0] inst_addr_i,
    input  logic [RegBus-1:0]     op1_i,
    input  logic [RegBus-1:0]     op2_i,
    input  logic [RegBus-1:0]     op1_jump_i,
    input  logic [RegBus-1:0]     op2_jump_i,
    input  logic [RegBus-1:0]     reg1_rdata_i,
    input  logic [RegBus-1:0]     reg2_rdata_i,
    input  logic                  reg_we_i,
    input  logic [RegAddrBus-1:0] reg_waddr_i,
    input  logic                  csr_we_i,
    input  logic [RegBus-1:0]     csr_rdata_i,
    input  logic [MemAddrBus-1:0] csr_waddr_i,
    output logic [InstBus-1:0]    inst_o,
    output logic [MemAddrBus-1:0] inst_addr_o,
    output logic [RegBus-1:0]     op1_o,
    output logic [RegBus-1:0]     op2_o,
    output logic [RegBus-1:0]     op1_jump_o,
    output logic [RegBus-1:0]     op2_jump_o,
    output logic [RegBus-1:0]     reg1_rdata_o,
    output logic [RegBus-1:0]     reg2_rdata_o,
    output logic                  reg_we_o,
    output logic [RegAddrBus-1:0] reg_waddr_o,
    output logic                  csr_we_o,
    output logic [RegBus-1:0]     csr_rdata_o,
    output logic [MemAddrBus-1:0] csr_waddr_o,
    output logic                  valid_o,
    output logic                  is_load_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      bubble_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    id_ex_t stage_q;
    id_ex_t cap;
    id_ex_t nop;

    always_comb begin
        nop            = nop_state(NOP_INST);
        cap            = '0;
        cap.inst       = inst_i;
        cap.inst_addr  = inst_addr_i;
        cap.op1        = op1_i;
        cap.op2        = op2_i;
        cap.op1_jump   = op1_jump_i;
        cap.op2_jump   = op2_jump_i;
        cap.reg1_rdata = reg1_rdata_i;
        cap.reg2_rdata = reg2_rdata_i;
        cap.reg_we     = reg_we_i;
        cap.reg_waddr  = reg_waddr_i;
        cap.csr_we     = csr_we_i;
        cap.csr_rdata  = csr_rdata_i;
        cap.csr_waddr  = csr_waddr_i;
        cap.valid      = 1'b1;
        cap.is_load    = is_load_inst(inst_i, reg_we_i);
    end

    // Stall holds everything, so a bubble still pending afterwards is taken later.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            stage_q <= nop;
        end else if (!stall_i) begin
            stage_q <= bubble_i ? nop : cap;
        end
    end

    assign inst_o       = stage_q.inst;
    assign inst_addr_o  = stage_q.inst_addr;
    assign op1_o        = stage_q.op1;
    assign op2_o        = stage_q.op2;
    assign op1_jump_o   = stage_q.op1_jump;
    assign op2_jump_o   = stage_q.op2_jump;
    assign reg1_rdata_o = stage_q.reg1_rdata;
    assign reg2_rdata_o = stage_q.reg2_rdata;
    assign reg_we_o     = stage_q.reg_we;
    assign reg_waddr_o  = stage_q.reg_waddr;
    assign csr_we_o     = stage_q.csr_we;
    assign csr_rdata_o  = stage_q.csr_rdata;
    assign csr_waddr_o  = stage_q.csr_waddr;
    assign valid_o      = stage_q.valid;
    assign is_load_o    = stage_q.is_load;

    logic flush_inc, stall_inc, bubble_inc;
    assign flush_inc  = flush_i;
    assign stall_inc  = !flush_i && stall_i;
    assign bubble_inc = !flush_i && !stall_i && bubble_i;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus randomized traffic checked
// against a behavioural model of the stage and its counters.
module tb_id_ex_pipe;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush_i, stall_i, bubble_i, cnt_clr_i;
    logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i;
    logic [31:0] reg1_rdata_i, reg2_rdata_i, csr_rdata_i, csr_waddr_i;
    logic        reg_we_i, csr_we_i;
    logic [4:0]  reg_waddr_i;

    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o;
    logic [31:0] reg1_rdata_o, reg2_rdata_o, csr_rdata_o, csr_waddr_o;
    logic        reg_we_o, csr_we_o, valid_o, is_load_o;
    logic [4:0]  reg_waddr_o;
    logic [CW-1:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;

    id_ex_pipe #(.CNT_W(CW), .NOP_INST(32'h0000_0001)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .bubble_i(bubble_i), .cnt_clr_i(cnt_clr_i),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .csr_we_i(csr_we_i),
        .csr_rdata_i(csr_rdata_i), .csr_waddr_i(csr_waddr_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
        .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .csr_we_o(csr_we_o),
        .csr_rdata_o(csr_rdata_o), .csr_waddr_o(csr_waddr_o),
        .valid_o(valid_o), .is_load_o(is_load_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_inst, m_addr, m_op1, m_op2, m_j1, m_j2, m_r1, m_r2, m_crd, m_cwa;
    logic        m_rwe, m_cwe, m_valid, m_load;
    logic [4:0]  m_rwa;
    logic [CW-1:0] m_sc, m_bc, m_fc;

    logic [340:0] obs, expv;
    assign obs = {inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o,
                  reg1_rdata_o, reg2_rdata_o, reg_we_o, reg_waddr_o, csr_we_o,
                  csr_rdata_o, csr_waddr_o, valid_o, is_load_o,
                  stall_cnt_o, bubble_cnt_o, flush_cnt_o};
    always_comb expv = {m_inst, m_addr, m_op1, m_op2, m_j1, m_j2, m_r1, m_r2,
                        m_rwe, m_rwa, m_cwe, m_crd, m_cwa, m_valid, m_load,
                        m_sc, m_bc, m_fc};

    task automatic model_nop();
        m_inst = 32'h1; m_addr = 0; m_op1 = 0; m_op2 = 0; m_j1 = 0; m_j2 = 0;
        m_r1 = 0; m_r2 = 0; m_crd = 0; m_cwa = 0;
        m_rwe = 0; m_cwe = 0; m_rwa = 0; m_valid = 0; m_load = 0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_nop();
            m_sc = 0; m_bc = 0; m_fc = 0;
        end else begin
            if (cnt_clr_i) begin
                m_sc = 0; m_bc = 0; m_fc = 0;
            end else if (flush_i) begin
                if (m_fc != CMAX) m_fc = m_fc + 1;
            end else if (stall_i) begin
                if (m_sc != CMAX) m_sc = m_sc + 1;
            end else if (bubble_i) begin
                if (m_bc != CMAX) m_bc = m_bc + 1;
            end
            if (flush_i) model_nop();
            else if (stall_i) ;
            else if (bubble_i) model_nop();
            else begin
                m_inst = inst_i; m_addr = inst_addr_i; m_op1 = op1_i; m_op2 = op2_i;
                m_j1 = op1_jump_i; m_j2 = op2_jump_i; m_r1 = reg1_rdata_i; m_r2 = reg2_rdata_i;
                m_rwe = reg_we_i; m_rwa = reg_waddr_i; m_cwe = csr_we_i;
                m_crd = csr_rdata_i; m_cwa = csr_waddr_i; m_valid = 1;
                m_load = (inst_i[6:0] == 7'b0000011) && reg_we_i;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_rand();
        inst_i = $urandom; inst_addr_i = $urandom; op1_i = $urandom; op2_i = $urandom;
        op1_jump_i = $urandom; op2_jump_i = $urandom;
        reg1_rdata_i = $urandom; reg2_rdata_i = $urandom;
        csr_rdata_i = $urandom; csr_waddr_i = $urandom;
        reg_we_i = 1'($urandom); csr_we_i = 1'($urandom); reg_waddr_i = 5'($urandom);
        if ($urandom_range(0, 2) == 0) inst_i[6:0] = 7'b0000011;
    endtask

    task automatic set_ctrl(input logic f, input logic s, input logic b, input logic c);
        flush_i = f; stall_i = s; bubble_i = b; cnt_clr_i = c;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_rand(); set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        step();
        drive_rand();
        step();
        checks++; if (inst_o !== 32'h1) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_o, 32'h1); end
        checks++; if (reg_we_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL reset_ctl got we=%b v=%b exp 0 0", reg_we_o, valid_o); end
        checks++; if ({stall_cnt_o, bubble_cnt_o, flush_cnt_o} !== '0) begin errors++; $display("FAIL reset_cnt got %h %h %h exp 0", stall_cnt_o, bubble_cnt_o, flush_cnt_o); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL reset_all got %h exp %h", obs, expv); end
        rst = 1'b1;
    endtask

    task automatic test_capture();
        set_ctrl(0, 0, 0, 0);
        drive_rand();
        inst_i = 32'h00A28293; op1_i = 5; op2_i = 10; reg_we_i = 1; reg_waddr_i = 5;
        step();
        checks++; if (op1_o !== 32'd5 || op2_o !== 32'd10) begin errors++; $display("FAIL capture_ops got %0d %0d exp 5 10", op1_o, op2_o); end
        checks++; if (reg_waddr_o !== 5'd5 || valid_o !== 1'b1 || is_load_o !== 1'b0) begin errors++; $display("FAIL capture_ctl got wa=%0d v=%b ld=%b exp 5 1 0", reg_waddr_o, valid_o, is_load_o); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL capture_all got %h exp %h", obs, expv); end
    endtask

    task automatic test_load_bubble();
        drive_rand();
        inst_i = 32'h0002A303; reg_we_i = 1;
        set_ctrl(0, 0, 0, 1);
        step();
        checks++; if (is_load_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL load_flag got ld=%b v=%b exp 1 1", is_load_o, valid_o); end
        drive_rand();
        set_ctrl(0, 0, 1, 0);
        step();
        checks++; if (inst_o !== 32'h1 || reg_we_o !== 1'b0 || is_load_o !== 1'b0) begin errors++; $display("FAIL bubble_nop got inst=%h we=%b ld=%b exp 1 0 0", inst_o, reg_we_o, is_load_o); end
        checks++; if (bubble_cnt_o !== 4'd1) begin errors++; $display("FAIL bubble_cnt got %0d exp 1", bubble_cnt_o); end
        // consecutive bubble
        drive_rand();
        step();
        checks++; if (obs !== expv) begin errors++; $display("FAIL bubble_twice got %h exp %h", obs, expv); end
        set_ctrl(0, 0, 0, 0);
    endtask

    task automatic test_stall_hold();
        logic [328:0] snap;
        drive_rand();
        set_ctrl(0, 0, 0, 1);
        step();
        snap = obs[340:12];
        set_ctrl(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            bubble_i = 1'($urandom);
            step();
            checks++; if (obs[340:12] !== snap) begin errors++; $display("FAIL stall_hold cyc %0d got %h exp %h", i, obs[340:12], snap); end
        end
        checks++; if (stall_cnt_o !== 4'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt_o); end
        set_ctrl(0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        logic [CW-1:0] ps, pb, pf;
        ps = m_sc; pb = m_bc; pf = m_fc;
        drive_rand();
        set_ctrl(1, 1, 1, 0);
        step();
        checks++; if (inst_o !== 32'h1 || valid_o !== 1'b0 || reg_we_o !== 1'b0 || csr_we_o !== 1'b0) begin errors++; $display("FAIL flush_nop got inst=%h v=%b we=%b cwe=%b", inst_o, valid_o, reg_we_o, csr_we_o); end
        checks++; if (flush_cnt_o !== pf + 1'b1 || stall_cnt_o !== ps || bubble_cnt_o !== pb) begin errors++; $display("FAIL flush_cnts got %0d %0d %0d exp %0d %0d %0d", flush_cnt_o, stall_cnt_o, bubble_cnt_o, pf + 1'b1, ps, pb); end
        drive_rand();
        set_ctrl(0, 1, 0, 1);
        step();
        checks++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin errors++; $display("FAIL clr_stall got s=%0d f=%0d exp 0 0", stall_cnt_o, flush_cnt_o); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL clr_all got %h exp %h", obs, expv); end
        set_ctrl(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        set_ctrl(0, 1, 0, 1);
        step();
        cnt_clr_i = 0;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            step();
        end
        checks++; if (stall_cnt_o !== 4'hF) begin errors++; $display("FAIL stall_sat got %h exp f", stall_cnt_o); end
        checks++; if (obs !== expv) begin errors++; $display("FAIL sat_all got %h exp %h", obs, expv); end
        set_ctrl(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive_rand(); reg_we_i = 1;
        step();
        set_ctrl(0, 1, 1, 0);
        step();
        rst = 1'b0;
        drive_rand();
        step();
        checks++; if (obs !== expv || valid_o !== 1'b0 || inst_o !== 32'h1) begin errors++; $display("FAIL reset_mid got %h exp %h", obs, expv); end
        rst = 1'b1;
        set_ctrl(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            set_ctrl($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            drive_rand();
            step();
            checks++; if (obs !== expv) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs, expv); end
            checks++; if (!valid_o && (reg_we_o || csr_we_o)) begin errors++; $display("FAIL nop_write cyc %0d got we=%b cwe=%b exp 0 0", i, reg_we_o, csr_we_o); end
        end
        rst = 1'b1;
        set_ctrl(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        set_ctrl(0, 0, 0, 0);
        drive_rand();
        test_reset();
        test_capture();
        test_load_bubble();
        test_stall_hold();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
